serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing Data_in_A − Data_in_B, one bit per clock, LSB first, with a start/done handshake. It is the inverse-direction companion to the team's ripple full-adder datapath, for area-constrained paths where a WIDTH-bit parallel subtractor is too large. One full-subtractor cell and a borrow flip-flop are reused across WIDTH cycles. Operands are latched at start and the result is held until the next start.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  single system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
Data_in_A  input  WIDTH  minuend; sampled on the accepted-start edge only.
Data_in_B  input  WIDTH  subtrahend; sampled on the accepted-start edge only.
busy  output  1  high while the SHIFT state is active.
done  output  1  single-cycle pulse; result valid from this cycle onward.
Data_out_Diff  output  WIDTH  A − B modulo 2^WIDTH.
Data_out_Borrow  output  1  final borrow; 1 when unsigned A < B.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0; done=0.
  - Data_out_Diff=0; Data_out_Borrow=0.
  - Internal operand shift registers, result shift register, bit counter and borrow flip-flop all 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 → latch A and B into shift registers, clear borrow flip-flop, count=0, go to SHIFT. start=0 → stay.
  - SHIFT: busy=1. Each cycle:
    - Compute d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin), where a0/b0 are the LSBs of the operand registers and bin is the borrow flip-flop.
    - Shift both operand registers right by 1.
    - Shift d into the MSB of the result register (right shift).
    - borrow flip-flop ← bout; count++.
    - When count==WIDTH-1 on this edge, go to DONE.
  - DONE: done=1 for exactly this one cycle.
    - Data_out_Diff ← result register; Data_out_Borrow ← borrow flip-flop. Both load on the SHIFT→DONE edge, so they are visible in the DONE cycle.
    - start=1 → accept new operands, go to SHIFT (back-to-back). Else go to IDLE.
- Latency: start accepted at edge N → done high during cycle N+WIDTH+1 (WIDTH SHIFT cycles, then DONE).
- Throughput: one result every WIDTH+1 cycles when start is held high.
- start during SHIFT is ignored: no queuing, operands are not re-sampled.
- Data_out_Diff and Data_out_Borrow hold their last value through IDLE and through a subsequent SHIFT. They change only on the SHIFT→DONE edge.
- Data_in_A and Data_in_B may change freely after the accepted-start edge without affecting the result.
- Reset mid-SHIFT: the operation is aborted with no done pulse and outputs return to 0. The first start after reset deasserts is handled normally.
- Arithmetic: pure modulo 2^WIDTH. The borrow output equals the unsigned comparison A<B. No signed-overflow flag.
- Counter width: $clog2(WIDTH); there is no wrap-around hazard because it is cleared at start.

Decomposition:
- Shared package (sub_pkg): state enum {IDLE, SHIFT, DONE} and the encoding constants.
- One natural combinational sub-module, full_subtractor (ports a, b, bin, d, bout), instantiated once in the serial datapath.
- The FSM, shift registers and counter stay in serial_subtractor.

Test Plan:
- WIDTH=8, A=200, B=55, start pulse → done exactly 9 cycles after the start edge; Diff=145, Borrow=0; busy high for 8 cycles.
- A=5, B=10 → Diff=251 (0xFB), Borrow=1; outputs hold after done until the next done.
- A=0, B=0, then A=255, B=255 back-to-back with start held high → two done pulses 9 cycles apart; both Diff=0, Borrow=0.
- start re-pulsed mid-SHIFT with A=1, B=2 while computing 100−1 → result Diff=99, Borrow=0; only one done pulse.
- reset asserted at SHIFT cycle 4 (asynchronously, between edges) → all outputs 0 immediately, no done pulse; a fresh start with 7−3 → Diff=4.
- Random A and B over 1000 iterations at WIDTH=8 and WIDTH=16 → Diff=(A−B) mod 2^WIDTH and Borrow=(A<B), checked against the scoreboard.

Source files
------------

// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor.
//   state_t  : controller states IDLE / SHIFT / DONE with fixed encodings
//   STATE_W  : width of the state encoding
// -----------------------------------------------------------------------------
package sub_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ENC_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ENC_SHIFT = 2'd1;
   localparam logic [STATE_W-1:0] ENC_DONE  = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = ENC_IDLE,
      SHIFT = ENC_SHIFT,
      DONE  = ENC_DONE
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor cell: computes a - b - bin.
// Ports:
//   a     in  1  minuend bit
//   b     in  1  subtrahend bit
//   bin   in  1  borrow in from the less significant bit
//   d     out 1  difference bit
//   bout  out 1  borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   // Borrow when b beats a outright, or when they tie and a borrow is pending.
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor, Data_in_A - Data_in_B, one bit per
// clock, LSB first. Operands are captured on the accepted-start edge; the
// result and final borrow are loaded on the last shift edge and held until the
// next result is produced.
// Ports:
//   clk              in  1      system clock, rising edge
//   reset            in  1      asynchronous active-high reset
//   start            in  1      request, honoured only in IDLE or DONE
//   Data_in_A        in  WIDTH  minuend
//   Data_in_B        in  WIDTH  subtrahend
//   busy             out 1      high during SHIFT
//   done             out 1      one-cycle pulse, result valid from here on
//   Data_out_Diff    out WIDTH  A - B modulo 2^WIDTH
//   Data_out_Borrow  out 1      1 when unsigned A < B
// -----------------------------------------------------------------------------
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] Data_in_A,
   input  logic [WIDTH-1:0] Data_in_B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Data_out_Diff,
   output logic             Data_out_Borrow
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_ff;
   logic             r_borrow_out;
   logic [CW-1:0]    r_count;

   logic             w_accept;
   logic             w_shift;
   logic             w_last;
   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_shifted;

   // A start is only honoured when no operation is in flight.
   assign w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_shift       = (r_state == SHIFT);
   assign w_last        = w_shift && (r_count == LAST_BIT);
   assign w_res_shifted = {w_d, r_res[WIDTH-1:1]};

   full_subtractor u_fs (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_borrow_ff),
      .d    (w_d),
      .bout (w_bout)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = SHIFT;
         SHIFT:   if (r_count == LAST_BIT) w_next_state = DONE;
         DONE:    w_next_state = start ? SHIFT : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_borrow_ff <= 1'b0;
         r_count     <= '0;
      end else if (w_accept) begin
         r_a         <= Data_in_A;
         r_b         <= Data_in_B;
         r_res       <= '0;
         r_borrow_ff <= 1'b0;
         r_count     <= '0;
      end else if (w_shift) begin
         r_a         <= r_a >> 1;
         r_b         <= r_b >> 1;
         r_res       <= w_res_shifted;
         r_borrow_ff <= w_bout;
         r_count     <= r_count + 1'b1;
      end
   end

   // The last difference bit and borrow are produced on the final shift edge,
   // so the outputs take them straight from the cell rather than the registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else if (w_last) begin
         r_diff       <= w_res_shifted;
         r_borrow_out <= w_bout;
      end
   end

   assign Data_out_Diff   = r_diff;
   assign Data_out_Borrow = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start8, start16;
   logic [7:0]  a8, b8, diff8;
   logic        brw8, busy8, done8;
   logic [15:0] a16, b16, diff16;
   logic        brw16, busy16, done16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk             (clk),
      .reset           (reset),
      .start           (start8),
      .Data_in_A       (a8),
      .Data_in_B       (b8),
      .busy            (busy8),
      .done            (done8),
      .Data_out_Diff   (diff8),
      .Data_out_Borrow (brw8)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk             (clk),
      .reset           (reset),
      .start           (start16),
      .Data_in_A       (a16),
      .Data_in_B       (b16),
      .busy            (busy16),
      .done            (done16),
      .Data_out_Diff   (diff16),
      .Data_out_Borrow (brw16)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       brw;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One operation on the selected DUT; lat counts edges from the one that
   // accepts start up to the one after which done is seen.
   task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] diff, output logic brw,
                         output int lat, output int busy_cnt);
      logic d_now;
      lat = 0;
      busy_cnt = 0;
      if (sel == 8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
      else begin a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
      tick;
      lat = 1;
      start8 = 1'b0;
      start16 = 1'b0;
      // operands must have been captured; disturb the inputs
      a8 = ~a8; b8 = b8 ^ 8'h5A; a16 = ~a16; b16 = b16 ^ 16'h3C5A;
      d_now = (sel == 8) ? done8 : done16;
      if (((sel == 8) ? busy8 : busy16) == 1'b1) busy_cnt++;
      while (!d_now && lat < 40) begin
         tick;
         lat++;
         if (((sel == 8) ? busy8 : busy16) == 1'b1) busy_cnt++;
         d_now = (sel == 8) ? done8 : done16;
      end
      diff = (sel == 8) ? {24'b0, diff8} : {16'b0, diff16};
      brw  = (sel == 8) ? brw8 : brw16;
   endtask

   initial begin
      logic [31:0] rd;
      logic        rb;
      int          lat, bc, nd, nxt, t, cnt;
      logic        was_done;
      int          dt[3];
      logic [7:0]  opa[3], opb[3], oexp[3];
      logic        obrw[3];
      logic [31:0] ra, rbv;
      longint      ea, eb;

      vecs = '{
         '{8'd200, 8'd55,  8'd145, 1'b0},
         '{8'd5,   8'd10,  8'd251, 1'b1},
         '{8'd0,   8'd0,   8'd0,   1'b0},
         '{8'd255, 8'd255, 8'd0,   1'b0},
         '{8'd100, 8'd1,   8'd99,  1'b0},
         '{8'd7,   8'd3,   8'd4,   1'b0},
         '{8'd0,   8'd1,   8'd255, 1'b1},
         '{8'd128, 8'd127, 8'd1,   1'b0},
         '{8'd127, 8'd128, 8'd255, 1'b1},
         '{8'd1,   8'd255, 8'd2,   1'b1},
         '{8'd255, 8'd0,   8'd255, 1'b0}
      };
      opa = '{8'd0, 8'd255, 8'd3};
      opb = '{8'd0, 8'd255, 8'd9};
      oexp = '{8'd0, 8'd0, 8'd250};
      obrw = '{1'b0, 1'b0, 1'b1};

      reset = 1'b1; start8 = 1'b0; start16 = 1'b0;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy8, 0);
      chk("reset_done", done8, 0);
      chk("reset_diff", diff8, 0);
      chk("reset_borrow", brw8, 0);
      chk("reset_diff16", diff16, 0);
      @(negedge clk);
      reset = 1'b0;
      tick;

      // ---- table-driven directed vectors
      for (int i = 0; i < 11; i++) begin
         run_op(8, {24'b0, vecs[i].a}, {24'b0, vecs[i].b}, rd, rb, lat, bc);
         $display("W8 vec%0d A=%0d B=%0d diff=%0d borrow=%0d lat=%0d busy=%0d",
                  i, vecs[i].a, vecs[i].b, rd, rb, lat, bc);
         chk("vec_latency", lat, 9);
         chk("vec_busy_cycles", bc, 8);
         chk("vec_diff", rd, vecs[i].diff);
         chk("vec_borrow", rb, vecs[i].brw);
         tick;
         chk("vec_done_pulse", done8, 0);
         chk("vec_diff_hold", diff8, vecs[i].diff);
      end

      // ---- outputs hold through IDLE and the following SHIFT
      run_op(8, 32'd5, 32'd10, rd, rb, lat, bc);
      $display("W8 hold A=5 B=10 diff=%0d borrow=%0d lat=%0d", rd, rb, lat);
      repeat (5) tick;
      chk("hold_idle_diff", diff8, 251);
      chk("hold_idle_borrow", brw8, 1);
      a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      tick; tick;
      chk("hold_shift_busy", busy8, 1);
      chk("hold_shift_diff", diff8, 251);
      chk("hold_shift_borrow", brw8, 1);
      cnt = 0;
      while (!done8 && cnt < 40) begin tick; cnt++; end
      chk("hold_next_diff", diff8, 145);
      $display("W8 hold-next A=200 B=55 diff=%0d borrow=%0d", diff8, brw8);
      tick;

      // ---- back-to-back with start held high
      for (int k = 0; k < 3; k++) dt[k] = 0;
      a8 = opa[0]; b8 = opb[0]; start8 = 1'b1;
      tick;
      a8 = opa[1]; b8 = opb[1];
      nxt = 2; nd = 0; was_done = 1'b0;
      for (t = 2; t <= 40 && nd < 3; t++) begin
         tick;
         if (was_done) begin
            if (nxt < 3) begin a8 = opa[nxt]; b8 = opb[nxt]; nxt++; end
            else start8 = 1'b0;
         end
         was_done = done8;
         if (done8) begin
            $display("W8 b2b op%0d A=%0d B=%0d diff=%0d borrow=%0d t=%0d",
                     nd, opa[nd], opb[nd], diff8, brw8, t);
            chk("b2b_diff", diff8, oexp[nd]);
            chk("b2b_borrow", brw8, obrw[nd]);
            dt[nd] = t;
            nd++;
         end
      end
      start8 = 1'b0;
      chk("b2b_done_count", nd, 3);
      chk("b2b_first_latency", dt[0], 9);
      chk("b2b_spacing1", dt[1] - dt[0], 9);
      chk("b2b_spacing2", dt[2] - dt[1], 9);
      tick;
      chk("b2b_idle", busy8, 0);

      // ---- start re-pulsed mid-SHIFT is ignored
      a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
      tick;
      lat = 1;
      start8 = 1'b0;
      tick; tick; lat += 2;
      a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
      tick; lat++;
      start8 = 1'b0;
      while (!done8 && lat < 40) begin tick; lat++; end
      $display("W8 repulse A=100 B=1 diff=%0d borrow=%0d lat=%0d", diff8, brw8, lat);
      chk("repulse_latency", lat, 9);
      chk("repulse_diff", diff8, 99);
      chk("repulse_borrow", brw8, 0);
      cnt = 0;
      repeat (12) begin tick; if (done8) cnt++; end
      chk("repulse_extra_done", cnt, 0);

      // ---- asynchronous reset during SHIFT
      run_op(8, 32'd5, 32'd10, rd, rb, lat, bc);
      chk("prereset_borrow", rb, 1);
      tick;
      a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      tick; tick; tick;
      #2 reset = 1'b1;
      #1;
      chk("areset_diff", diff8, 0);
      chk("areset_borrow", brw8, 0);
      chk("areset_busy", busy8, 0);
      chk("areset_done", done8, 0);
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      repeat (12) begin tick; if (done8) cnt++; end
      chk("areset_no_done", cnt, 0);
      run_op(8, 32'd7, 32'd3, rd, rb, lat, bc);
      $display("W8 post-reset A=7 B=3 diff=%0d borrow=%0d lat=%0d", rd, rb, lat);
      chk("post_reset_latency", lat, 9);
      chk("post_reset_diff", rd, 4);
      chk("post_reset_borrow", rb, 0);
      tick;

      // ---- random scoreboard, WIDTH=8 then WIDTH=16
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom_range(0, 255);
         rbv = $urandom_range(0, 255);
         run_op(8, ra, rbv, rd, rb, lat, bc);
         ea = ra; eb = rbv;
         $display("W8 rnd%0d A=%0d B=%0d diff=%0d borrow=%0d", i, ra, rbv, rd, rb);
         chk("rnd8_diff", rd, (ea - eb) & 255);
         chk("rnd8_borrow", rb, (ea < eb) ? 1 : 0);
         chk("rnd8_latency", lat, 9);
      end
      tick;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom_range(0, 65535);
         rbv = $urandom_range(0, 65535);
         run_op(16, ra, rbv, rd, rb, lat, bc);
         ea = ra; eb = rbv;
         $display("W16 rnd%0d A=%0d B=%0d diff=%0d borrow=%0d", i, ra, rbv, rd, rb);
         chk("rnd16_diff", rd, (ea - eb) & 65535);
         chk("rnd16_borrow", rb, (ea < eb) ? 1 : 0);
         chk("rnd16_latency", lat, 17);
         chk("rnd16_busy_cycles", bc, 16);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
